// File: rtl/score_fill_controller_pkg.sv
// Shared definitions for the score RAM management modules.
//   - FSM state encodings of the score fill controller
//   - score word width and type
//   - init_score(): initial border score -k*gap, truncated to the score width
package score_fill_controller_pkg;

    localparam int SCORE_W = 9;

    typedef logic [SCORE_W-1:0] score_t;

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_INIT_ROW   = 3'd1;
    localparam logic [2:0] ST_INIT_COL   = 3'd2;
    localparam logic [2:0] ST_FILL_REQ   = 3'd3;
    localparam logic [2:0] ST_FILL_WRITE = 3'd4;
    localparam logic [2:0] ST_DONE       = 3'd5;

    // The product is formed in 16 bits so that the largest legal value
    // (255) cannot wrap before negation. Only the low score bits are kept.
    function automatic score_t init_score(input logic [15:0] k, input logic [15:0] gap);
        logic [15:0] neg;
        neg = 16'd0 - (k * gap);
        return neg[SCORE_W-1:0];
    endfunction

endpackage

// File: rtl/score_fill_controller_fill_index_counter.sv
// Row-major (i,j) index counter for the matrix fill phase.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   clear      : return to (0,0)
//   advance    : step to the next cell; (N-1,N-1) wraps to (0,0)
//   i, j       : current cell coordinates, 0..N-1
//   last_cell  : current cell is (N-1,N-1)
module fill_index_counter #(
    parameter int N       = 128,
    parameter int BitAddr = $clog2(N+1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             advance,
    output logic [BitAddr:0] i,
    output logic [BitAddr:0] j,
    output logic             last_cell
);

    localparam int unsigned    LAST_U   = N - 1;
    localparam logic [BitAddr:0] IDX_LAST = LAST_U[BitAddr:0];

    logic wrap_j;

    assign wrap_j    = (j == IDX_LAST);
    assign last_cell = wrap_j && (i == IDX_LAST);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            i <= '0;
            j <= '0;
        end else if (advance) begin
            if (wrap_j) begin
                j <= '0;
                i <= last_cell ? '0 : i + 1'b1;
            end else begin
                j <= j + 1'b1;
            end
        end
    end

endmodule

// File: rtl/score_fill_controller.sv
// Sequencer for filling an (N+1)x(N+1) alignment score matrix: writes the
// row-0 and column-0 borders with -k*GAP, then walks the interior cells in
// row-major order, handshaking with the compute unit for each one.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   start             : level request to begin a fill (sampled in IDLE only)
//   max_valid         : compute result ready (sampled in FILL_REQ only)
//   en_init, hit      : border write strobe; hit=0 row 0, hit=1 column 0
//   addr_init         : border cell index k
//   data_init         : border score -k*GAP
//   en_ins            : interior write strobe for cell (i+1,j+1)
//   i, j              : current interior coordinates
//   calc_req          : compute request for (i,j)
//   busy, done        : not-idle flag, one-cycle completion pulse
//
// state       | meaning
// ------------+-----------------------------------------------
// IDLE        | waiting for start
// INIT_ROW    | writing row 0, k = 0..N
// INIT_COL    | writing column 0, k = 1..N ((0,0) already done)
// FILL_REQ    | calc_req high, holding (i,j) until max_valid
// FILL_WRITE  | en_ins pulse for (i,j), then advance
// DONE        | done pulse, back to IDLE
module score_fill_controller
    import score_fill_controller_pkg::*;
#(
    parameter int N       = 128,
    parameter int GAP     = 1,
    parameter int BitAddr = $clog2(N+1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               max_valid,
    output logic               en_init,
    output logic               hit,
    output logic [BitAddr:0]   addr_init,
    output logic [SCORE_W-1:0] data_init,
    output logic               en_ins,
    output logic [BitAddr:0]   i,
    output logic [BitAddr:0]   j,
    output logic               calc_req,
    output logic               busy,
    output logic               done
);

    localparam int unsigned      N_U   = N;
    localparam logic [BitAddr:0] IDX_N = N_U[BitAddr:0];

    logic [2:0]       state_q, state_nxt;
    logic [BitAddr:0] k_q, k_nxt;
    logic             cnt_clear, cnt_adv, last_cell;
    logic             init_nxt;

    fill_index_counter #(
        .N       (N),
        .BitAddr (BitAddr)
    ) u_index (
        .clk       (clk),
        .rst       (rst),
        .clear     (cnt_clear),
        .advance   (cnt_adv),
        .i         (i),
        .j         (j),
        .last_cell (last_cell)
    );

    always_comb begin
        state_nxt = state_q;
        k_nxt     = k_q;
        cnt_clear = 1'b0;
        cnt_adv   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_INIT_ROW;
                    k_nxt     = '0;
                end
            end
            ST_INIT_ROW: begin
                if (k_q == IDX_N) begin
                    state_nxt = ST_INIT_COL;
                    k_nxt     = {{BitAddr{1'b0}}, 1'b1};
                end else begin
                    k_nxt = k_q + 1'b1;
                end
            end
            ST_INIT_COL: begin
                if (k_q == IDX_N) begin
                    state_nxt = ST_FILL_REQ;
                    k_nxt     = '0;
                    cnt_clear = 1'b1;
                end else begin
                    k_nxt = k_q + 1'b1;
                end
            end
            ST_FILL_REQ: begin
                if (max_valid) begin
                    state_nxt = ST_FILL_WRITE;
                end
            end
            ST_FILL_WRITE: begin
                cnt_adv   = 1'b1;
                state_nxt = last_cell ? ST_DONE : ST_FILL_REQ;
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
                k_nxt     = '0;
            end
        endcase
    end

    assign init_nxt = (state_nxt == ST_INIT_ROW) || (state_nxt == ST_INIT_COL);

    // Outputs are registered from the next-state decode so they line up
    // with the state they describe and stay zero whenever not strobing.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            k_q       <= '0;
            en_init   <= 1'b0;
            hit       <= 1'b0;
            addr_init <= '0;
            data_init <= '0;
            en_ins    <= 1'b0;
            calc_req  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_q   <= state_nxt;
            k_q       <= k_nxt;
            en_init   <= init_nxt;
            hit       <= (state_nxt == ST_INIT_COL);
            addr_init <= init_nxt ? k_nxt : '0;
            data_init <= init_nxt ? init_score(16'(k_nxt), 16'(GAP)) : '0;
            en_ins    <= (state_nxt == ST_FILL_WRITE);
            calc_req  <= (state_nxt == ST_FILL_REQ);
            busy      <= (state_nxt != ST_IDLE);
            done      <= (state_nxt == ST_DONE);
        end
    end

endmodule

// File: tb/tb_score_fill_controller.sv
module tb_score_fill_controller;

    localparam int N = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start, max_valid, start2, mv2;
    logic       en_init, hit, en_ins, calc_req, busy, done;
    logic [3:0] addr_init, i, j;
    logic [8:0] data_init;

    logic       g2_en_init, g2_hit, g2_en_ins, g2_calc_req, g2_busy, g2_done;
    logic [3:0] g2_addr_init, g2_i, g2_j;
    logic [8:0] g2_data_init;

    score_fill_controller #(.N(N), .GAP(1)) dut (
        .clk(clk), .rst(rst), .start(start), .max_valid(max_valid),
        .en_init(en_init), .hit(hit), .addr_init(addr_init), .data_init(data_init),
        .en_ins(en_ins), .i(i), .j(j), .calc_req(calc_req), .busy(busy), .done(done)
    );

    score_fill_controller #(.N(N), .GAP(63)) dut_gap63 (
        .clk(clk), .rst(rst), .start(start2), .max_valid(mv2),
        .en_init(g2_en_init), .hit(g2_hit), .addr_init(g2_addr_init), .data_init(g2_data_init),
        .en_ins(g2_en_ins), .i(g2_i), .j(g2_j), .calc_req(g2_calc_req), .busy(g2_busy), .done(g2_done)
    );

    typedef struct packed {
        logic       en_init;
        logic       hit;
        logic [3:0] addr;
        logic [8:0] data;
        logic       en_ins;
        logic [3:0] i;
        logic [3:0] j;
        logic       calc_req;
        logic       busy;
        logic       done;
    } outs_t;

    typedef struct {
        logic  start;
        logic  mv;
        outs_t exp;
    } vec_t;

    vec_t  tbl[$];
    int    total = 0;
    int    bad = 0;
    int    idx13 = 0;
    outs_t got;
    logic [8:0] neg1 [5];

    assign got = {en_init, hit, addr_init, data_init, en_ins, i, j, calc_req, busy, done};

    function automatic outs_t o_init(int k, bit col);
        outs_t o = '0;
        o.en_init = 1'b1;
        o.hit     = col;
        o.addr    = 4'(k);
        o.data    = neg1[k];
        o.busy    = 1'b1;
        return o;
    endfunction

    function automatic outs_t o_fill(int ci, int cj, bit wr);
        outs_t o = '0;
        o.i        = 4'(ci);
        o.j        = 4'(cj);
        o.calc_req = !wr;
        o.en_ins   = wr;
        o.busy     = 1'b1;
        return o;
    endfunction

    function automatic outs_t o_done();
        outs_t o = '0;
        o.done = 1'b1;
        o.busy = 1'b1;
        return o;
    endfunction

    task automatic push(input bit s, input bit m, input outs_t e);
        vec_t v;
        v.start = s;
        v.mv    = m;
        v.exp   = e;
        tbl.push_back(v);
    endtask

    // Expected sequence for one full fill; (di,dj) gets 'delay' extra
    // cycles with max_valid low, sp adds spurious start/max_valid.
    task automatic build(input int di, input int dj, input int delay, input bit sp);
        tbl.delete();
        push(1'b1, sp, o_init(0, 1'b0));
        for (int k = 1; k <= N; k++) push(1'b0, sp & k[0], o_init(k, 1'b0));
        for (int k = 1; k <= N; k++) push(1'b0, sp, o_init(k, 1'b1));
        for (int ci = 0; ci < N; ci++) begin
            for (int cj = 0; cj < N; cj++) begin
                if (ci == 1 && cj == 3) idx13 = tbl.size();
                push(1'b0, sp, o_fill(ci, cj, 1'b0));
                if (ci == di && cj == dj)
                    for (int d = 0; d < delay; d++) push(1'b1, 1'b0, o_fill(ci, cj, 1'b0));
                push(sp, 1'b1, o_fill(ci, cj, 1'b1));
            end
        end
        push(1'b0, 1'b0, o_done());
        push(1'b0, 1'b0, '0);
    endtask

    task automatic check(input string nm, input outs_t e);
        total++;
        if (got !== e) begin
            bad++;
            $display("FAIL %s: got en_init=%b hit=%b addr=%0d data=%h en_ins=%b i=%0d j=%0d calc_req=%b busy=%b done=%b; want en_init=%b hit=%b addr=%0d data=%h en_ins=%b i=%0d j=%0d calc_req=%b busy=%b done=%b",
                     nm, got.en_init, got.hit, got.addr, got.data, got.en_ins, got.i, got.j,
                     got.calc_req, got.busy, got.done, e.en_init, e.hit, e.addr, e.data,
                     e.en_ins, e.i, e.j, e.calc_req, e.busy, e.done);
        end
    endtask

    task automatic check9(input string nm, input logic [8:0] g, input logic [8:0] e);
        total++;
        if (g !== e) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, g, e);
        end
    endtask

    task automatic run_table(input string tag, input int lim);
        for (int n = 0; n < lim; n++) begin
            start     = tbl[n].start;
            max_valid = tbl[n].mv;
            @(posedge clk);
            #1;
            check($sformatf("%s[%0d]", tag, n), tbl[n].exp);
        end
        start     = 1'b0;
        max_valid = 1'b0;
    endtask

    task automatic do_reset(input string nm);
        rst       = 1'b1;
        start     = 1'b0;
        max_valid = 1'b0;
        @(posedge clk);
        #1;
        check(nm, '0);
        rst = 1'b0;
    endtask

    initial begin
        neg1[0] = 9'h000; neg1[1] = 9'h1FF; neg1[2] = 9'h1FE;
        neg1[3] = 9'h1FD; neg1[4] = 9'h1FC;
        rst = 1'b1; start = 1'b0; max_valid = 1'b0; start2 = 1'b0; mv2 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset", '0);
        rst = 1'b0;

        // GAP=63 border scores
        start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        check9("gap63_k0", g2_data_init, 9'h000);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check9("gap63_k2", g2_data_init, 9'h182);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check9("gap63_k4", g2_data_init, 9'h104);
        check9("gap63_addr4", {5'd0, g2_addr_init}, 9'd4);

        // full fill with spurious start/max_valid sprinkled in
        build(-1, -1, 0, 1'b1);
        run_table("spur", tbl.size());

        // max_valid delayed 5 cycles at (2,1)
        build(2, 1, 5, 1'b0);
        run_table("delay", tbl.size());

        // reset mid-init (k=2) and mid-fill (1,3), each followed by a full replay
        build(-1, -1, 0, 1'b0);
        run_table("pre_rst_init", 3);
        do_reset("rst_init_k2");
        run_table("replay1", tbl.size());
        run_table("pre_rst_fill", idx13 + 1);
        do_reset("rst_fill_1_3");
        run_table("replay2", tbl.size());

        // start held high through DONE restarts on the first IDLE cycle
        run_table("held", tbl.size() - 2);
        start = 1'b1;
        @(posedge clk); #1;
        check("held_done", o_done());
        @(posedge clk); #1;
        check("held_idle", '0);
        @(posedge clk); #1;
        check("held_restart", o_init(0, 1'b0));
        start = 1'b0;
        do_reset("final_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/score_fill_controller.md
SCORE_FILL_CONTROLLER -- requirements
Module: score_fill_controller

Interface
REQ-001 SHALL have parameter N, default 128: sequence length; the matrix is (N+1)x(N+1).
REQ-002 SHALL have parameter GAP, default 1: linear gap penalty; legal range 1..255/N.
REQ-003 SHALL have parameter BitAddr, default $clog2(N+1): index width minus one.
REQ-004 SHALL have clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have rst  input  1  reset; synchronous and active-high.
REQ-006 SHALL have start  input  1  level-sampled request to begin a full matrix fill.
REQ-007 SHALL have max_valid  input  1  compute unit reports that the max for the current (i,j) is ready.
REQ-008 SHALL have en_init  output  1  init write strobe to the score write-index stage.
REQ-009 SHALL have hit  output  1  0 = row-0 init address; 1 = column-0 init address (stage multiplies by N+1).
REQ-010 SHALL have addr_init  output  BitAddr+1  init cell index k.
REQ-011 SHALL have data_init  output  9  init score, -k*GAP, 9-bit two's complement.
REQ-012 SHALL have en_ins  output  1  fill write strobe; cell (i+1,j+1) gets the compute max.
REQ-013 SHALL have i, j  output  BitAddr+1 each  current fill coordinates, 0..N-1.
REQ-014 SHALL have calc_req  output  1  request to the compute unit for cell (i,j).
REQ-015 SHALL have busy  output  1  high in every state except IDLE.
REQ-016 SHALL have done  output  1  one-cycle completion pulse.

Function
REQ-017 SHALL implement the states IDLE, INIT_ROW, INIT_COL, FILL_REQ, FILL_WRITE and DONE as a registered FSM with registered outputs.
REQ-018 IDLE: on start=1, SHALL move to INIT_ROW with k=0; start SHALL be ignored in all other states.
REQ-019 INIT_ROW: SHALL drive en_init=1, hit=0, addr_init=k, data_init=-k*GAP for k=0..N, one cell per cycle; after k=N SHALL move to INIT_COL with k=1.
REQ-020 INIT_COL: SHALL drive en_init=1, hit=1, addr_init=k, data_init=-k*GAP for k=1..N; cell (0,0) SHALL NOT be written twice; after k=N SHALL move to FILL_REQ with i=j=0.
REQ-021 Init SHALL therefore take exactly 2N+1 cycles with en_init high continuously.
REQ-022 FILL_REQ: SHALL hold calc_req=1 and i, j stable until max_valid=1 is sampled, then move to FILL_WRITE; the wait has no limit.
REQ-023 FILL_WRITE: SHALL pulse en_ins=1 for one cycle with i, j unchanged and calc_req=0, then advance coordinates.
REQ-024 Coordinates SHALL advance in row-major order: j increments; when j=N-1, j wraps to 0 and i increments.
REQ-025 After FILL_WRITE of (N-1,N-1), SHALL move to DONE; DONE SHALL pulse done=1 for one cycle and then return to IDLE.
REQ-026 max_valid outside FILL_REQ SHALL be ignored.
REQ-027 en_init and en_ins SHALL never be high in the same cycle.
REQ-028 When not strobing, addr_init, data_init and hit SHALL be 0, so the downstream stage sees idle zeros.
REQ-029 A start held high through DONE SHALL begin a new fill on the first cycle back in IDLE.
REQ-030 -k*GAP SHALL be computed in at least 10 bits and truncated to 9 bits.

Reset
REQ-031 rst=1 SHALL force IDLE with every output 0 and k, i, j set to 0 on the next edge, including mid-init and mid-fill.
REQ-032 The first start after reset deassertion SHALL behave as a fresh fill.

Structure
REQ-033 The state encoding localparams and the score width (9) SHALL live in a shared package header used by the score RAM management modules.
REQ-034 Index counting MAY be factored into one sub-module, fill_index_counter, holding i, j and the wrap and last-cell flags; everything else stays flat.

Verification
REQ-035 N=4, GAP=1, start pulse: en_init high for 9 cycles. Row: addr 0..4 with data 0,1FF,1FE,1FD,1FC (hex). Column: hit=1, addr 1..4, same data pattern minus 0.
REQ-036 N=4, compute returns max_valid the cycle after each calc_req: 16 en_ins pulses in order (0,0),(0,1)..(3,3), then exactly one done pulse, then busy=0.
REQ-037 max_valid delayed 5 cycles at (2,1): calc_req, i=2 and j=1 held for all 5 cycles; no en_ins until the cycle after max_valid.
REQ-038 rst asserted at init k=2 and again at fill (1,3): all outputs 0 next cycle; a new start replays the full sequence from k=0.
REQ-039 Spurious max_valid in IDLE and INIT, plus start pulses during FILL: no en_ins, no restart, and the sequence is unchanged.
REQ-040 N=4, GAP=63: data_init at k=4 equals 9'h104 (-252).
